// File: rtl/nv_mem_pkg.sv
// Shared types and sizes for the nv_memory front-end controller.
package nv_mem_pkg;

   localparam int ADDR_W    = 8;
   localparam int DATA_W    = 64;
   localparam int MEM_DEPTH = 256;
   localparam int PORT0     = 0;
   localparam int PORT1     = 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_RESP
   } nv_state_e;

endpackage

// File: rtl/nv_mem_ctrl_if.sv
// Request/response bundle between the two requesters and nv_mem_ctrl.
interface nv_mem_ctrl_if;
   import nv_mem_pkg::*;

   logic              p0_req,    p1_req;
   logic              p0_we,     p1_we;
   logic [ADDR_W-1:0] p0_addr,   p1_addr;
   logic [DATA_W-1:0] p0_wdata,  p1_wdata;
   logic              p0_gnt,    p1_gnt;
   logic              p0_err,    p1_err;
   logic              p0_rvalid, p1_rvalid;
   logic [DATA_W-1:0] rdata;

   modport master (
      output p0_req, p1_req, p0_we, p1_we, p0_addr, p1_addr, p0_wdata, p1_wdata,
      input  p0_gnt, p1_gnt, p0_err, p1_err, p0_rvalid, p1_rvalid, rdata
   );

   modport slave (
      input  p0_req, p1_req, p0_we, p1_we, p0_addr, p1_addr, p0_wdata, p1_wdata,
      output p0_gnt, p1_gnt, p0_err, p1_err, p0_rvalid, p1_rvalid, rdata
   );

endinterface

// File: rtl/nv_rr_arb2.sv
// Two-requester round-robin arbiter; the last-grant flop only moves when upd_en is set.
module nv_rr_arb2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       upd_en,
   output logic [1:0] gnt
);

   // last = 1 means port 1 was granted last, so port 0 has priority
   logic last;

   always_comb begin
      gnt = 2'b00;
      if (req[0] && (!req[1] || last)) gnt[0] = 1'b1;
      else if (req[1])                 gnt[1] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                 last <= 1'b1;
      else if (upd_en && |gnt)    last <= gnt[1];
   end

endmodule

// File: rtl/nv_mem_ctrl.sv
// Shares the single-port nv_memory between the decryptor (port 0) and the loader (port 1),
// one access at a time, with a sticky lock protecting the key region.
module nv_mem_ctrl
   import nv_mem_pkg::*;
#(
   parameter logic [ADDR_W-1:0] KEY_BASE = 8'hC0,
   parameter int                RD_LAT   = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   nv_mem_ctrl_if.slave      bus,
   input  logic              lock_set,
   output logic              locked,
   output logic              mem_w,
   output logic [ADDR_W-1:0] mem_addr_in,
   output logic [DATA_W-1:0] mem_data_in,
   input  logic [DATA_W-1:0] mem_data_out
);

   nv_state_e         state;
   logic [1:0]        req, arb_gnt;
   logic [1:0]        gnt_q, err_q, rvalid_q;
   logic [DATA_W-1:0] rdata_q;
   logic [1:0]        wcnt;
   logic              own, rd_q;
   logic              win, sel_we, refuse;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;

   assign req = {bus.p1_req, bus.p0_req};

   nv_rr_arb2 u_arb (
      .clk    (clk),
      .rst_n  (rst_n),
      .req    (req),
      .upd_en (state == ST_IDLE),
      .gnt    (arb_gnt)
   );

   assign win       = arb_gnt[PORT1];
   assign sel_we    = win ? bus.p1_we    : bus.p0_we;
   assign sel_addr  = win ? bus.p1_addr  : bus.p0_addr;
   assign sel_wdata = win ? bus.p1_wdata : bus.p0_wdata;
   // Port 0 (decryptor) may still read keys once locked; nobody may write them.
   assign refuse    = locked && (sel_addr >= KEY_BASE) && (sel_we || win);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) locked <= 1'b0;
      else        locked <= locked | lock_set;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         gnt_q       <= '0;
         err_q       <= '0;
         rvalid_q    <= '0;
         rdata_q     <= '0;
         mem_w       <= 1'b0;
         mem_addr_in <= '0;
         mem_data_in <= '0;
         wcnt        <= '0;
         own         <= 1'b0;
         rd_q        <= 1'b0;
      end else begin
         gnt_q    <= '0;
         err_q    <= '0;
         rvalid_q <= '0;
         mem_w    <= 1'b0;
         case (state)
            ST_IDLE: if (|req) begin
               own         <= win;
               mem_addr_in <= sel_addr;
               mem_data_in <= sel_wdata;
               gnt_q       <= arb_gnt;
               err_q       <= refuse ? arb_gnt : 2'b00;
               mem_w       <= sel_we && !refuse;
               rd_q        <= !sel_we && !refuse;
               state       <= ST_ISSUE;
            end
            ST_ISSUE: begin
               wcnt  <= 2'(RD_LAT - 1);
               state <= rd_q ? ST_WAIT : ST_IDLE;
            end
            ST_WAIT: begin
               if (wcnt == 2'd0) begin
                  rdata_q       <= mem_data_out;
                  rvalid_q[own] <= 1'b1;
                  state         <= ST_RESP;
               end else begin
                  wcnt <= wcnt - 2'd1;
               end
            end
            ST_RESP: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.p0_gnt    = gnt_q[PORT0];
   assign bus.p1_gnt    = gnt_q[PORT1];
   assign bus.p0_err    = err_q[PORT0];
   assign bus.p1_err    = err_q[PORT1];
   assign bus.p0_rvalid = rvalid_q[PORT0];
   assign bus.p1_rvalid = rvalid_q[PORT1];
   assign bus.rdata     = rdata_q;

endmodule

// File: tb/tb_nv_mem_ctrl.sv
// Directed bench for nv_mem_ctrl with a behavioural 1-cycle-latency nv_memory.
module tb_nv_mem_ctrl;
   import nv_mem_pkg::*;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              lock_set = 1'b0;
   logic              preload = 1'b1;
   logic              locked, mem_w;
   logic [ADDR_W-1:0] mem_addr_in;
   logic [DATA_W-1:0] mem_data_in, mem_data_out;
   logic [DATA_W-1:0] mem [MEM_DEPTH];
   logic [1:0]        gnt_v, err_v, rvalid_v;
   int                errs = 0;
   int                checks = 0;

   localparam logic [63:0] V_BF = 64'hBFBF_0000_1111_2222;
   localparam logic [63:0] V_C0 = 64'hDEAD_BEEF_0000_00C0;
   localparam logic [63:0] V_D0 = 64'h5555_AAAA_0000_00D0;

   nv_mem_ctrl_if bus ();

   nv_mem_ctrl #(.KEY_BASE(8'hC0), .RD_LAT(1)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .bus          (bus),
      .lock_set     (lock_set),
      .locked       (locked),
      .mem_w        (mem_w),
      .mem_addr_in  (mem_addr_in),
      .mem_data_in  (mem_data_in),
      .mem_data_out (mem_data_out)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (preload) begin
         mem[1]     <= 64'd555;
         mem[200]   <= 64'd2560;
         mem[8'hBF] <= V_BF;
         mem[8'hC0] <= V_C0;
      end else begin
         if (mem_w) mem[mem_addr_in] <= mem_data_in;
         mem_data_out <= mem[mem_addr_in];
      end
   end

   assign gnt_v    = {bus.p1_gnt, bus.p0_gnt};
   assign err_v    = {bus.p1_err, bus.p0_err};
   assign rvalid_v = {bus.p1_rvalid, bus.p0_rvalid};

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h want %0h", tag, act, exp);
      end
   endtask

   task automatic drive(input bit p, input bit r, input bit we, input logic [7:0] a,
                        input logic [63:0] wd);
      if (!p) begin
         bus.p0_req = r; bus.p0_we = we; bus.p0_addr = a; bus.p0_wdata = wd;
      end else begin
         bus.p1_req = r; bus.p1_we = we; bus.p1_addr = a; bus.p1_wdata = wd;
      end
   endtask

   // Called at a negedge with the FSM idle; req is seen on the following posedge.
   task automatic access(input bit p, input bit we, input logic [7:0] a, input logic [63:0] wd,
                         input bit lk, input bit exp_err, input logic [63:0] exp_rd);
      logic [1:0] oh;
      oh = p ? 2'b10 : 2'b01;
      chk("mem_w_pre", 64'(mem_w), 64'd0);
      drive(p, 1'b1, we, a, wd);
      lock_set = lk;
      @(negedge clk);
      drive(p, 1'b0, we, a, wd);
      lock_set = 1'b0;
      chk("gnt", 64'(gnt_v), 64'(oh));
      chk("err", 64'(err_v), exp_err ? 64'(oh) : 64'd0);
      chk("mem_w_issue", 64'(mem_w), 64'(we && !exp_err));
      chk("mem_addr", 64'(mem_addr_in), 64'(a));
      if (we || exp_err) begin
         @(negedge clk);
         chk("mem_w_after", 64'(mem_w), 64'd0);
         chk("gnt_after", 64'(gnt_v), 64'd0);
         if (!we) begin
            repeat (3) begin
               @(negedge clk);
               chk("no_rvalid", 64'(rvalid_v), 64'd0);
            end
            chk("rdata_kept", bus.rdata, exp_rd);
         end
      end else begin
         @(negedge clk);
         chk("rvalid_wait", 64'(rvalid_v), 64'd0);
         @(negedge clk);
         chk("rvalid", 64'(rvalid_v), 64'(oh));
         chk("rdata", bus.rdata, exp_rd);
         @(negedge clk);
         chk("rvalid_end", 64'(rvalid_v), 64'd0);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      drive(1'b0, 1'b0, 1'b0, 8'd0, 64'd0);
      drive(1'b1, 1'b0, 1'b0, 8'd0, 64'd0);
      repeat (2) @(negedge clk);
      chk("rst_gnt", 64'(gnt_v), 64'd0);
      chk("rst_err", 64'(err_v), 64'd0);
      chk("rst_rvalid", 64'(rvalid_v), 64'd0);
      chk("rst_rdata", bus.rdata, 64'd0);
      chk("rst_locked", 64'(locked), 64'd0);
      chk("rst_mem_w", 64'(mem_w), 64'd0);
      chk("rst_addr", 64'(mem_addr_in), 64'd0);
      chk("rst_wdata", mem_data_in, 64'd0);
      preload = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);

      // Port 1 write then read-back
      access(1'b1, 1'b1, 8'd0, 64'd256, 1'b0, 1'b0, 64'd0);
      access(1'b1, 1'b0, 8'd0, 64'd0, 1'b0, 1'b0, 64'd256);

      // Both ports hold read requests: grants alternate starting with port 0
      drive(1'b0, 1'b1, 1'b0, 8'd1, 64'd0);
      drive(1'b1, 1'b1, 1'b0, 8'd200, 64'd0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("rr_gnt", 64'(gnt_v), (i % 2) ? 64'd2 : 64'd1);
         @(negedge clk);
         @(negedge clk);
         chk("rr_rvalid", 64'(rvalid_v), (i % 2) ? 64'd2 : 64'd1);
         chk("rr_rdata", bus.rdata, (i % 2) ? 64'd2560 : 64'd555);
         @(negedge clk);
         chk("rr_idle", 64'(gnt_v), 64'd0);
         if (i == 3) begin
            drive(1'b0, 1'b0, 1'b0, 8'd0, 64'd0);
            drive(1'b1, 1'b0, 1'b0, 8'd0, 64'd0);
         end
      end
      @(negedge clk);

      // Lock, refused key write, port-0 key read still allowed
      lock_set = 1'b1;
      @(negedge clk);
      lock_set = 1'b0;
      chk("locked", 64'(locked), 64'd1);
      access(1'b1, 1'b1, 8'hC8, 64'hFFFF, 1'b0, 1'b1, 64'd0);
      access(1'b0, 1'b0, 8'hC8, 64'd0, 1'b0, 1'b0, 64'd2560);

      // Port-1 key read refused; just below the region is fine
      access(1'b1, 1'b0, 8'hC0, 64'd0, 1'b0, 1'b1, 64'd2560);
      access(1'b1, 1'b0, 8'hBF, 64'd0, 1'b0, 1'b0, V_BF);

      // lock_set coincident with arbitration does not affect that access
      do_reset();
      chk("unlocked", 64'(locked), 64'd0);
      access(1'b1, 1'b1, 8'hD0, V_D0, 1'b1, 1'b0, 64'd0);
      chk("locked_after", 64'(locked), 64'd1);
      access(1'b1, 1'b1, 8'hD0, 64'hFFFF, 1'b0, 1'b1, 64'd0);
      access(1'b0, 1'b0, 8'hD0, 64'd0, 1'b0, 1'b0, V_D0);

      // Reset during WAIT of a port-0 read
      drive(1'b0, 1'b1, 1'b0, 8'd1, 64'd0);
      @(negedge clk);
      chk("pre_rst_gnt", 64'(gnt_v), 64'd1);
      drive(1'b0, 1'b0, 1'b0, 8'd1, 64'd0);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rst_async_locked", 64'(locked), 64'd0);
      chk("rst_async_mem_w", 64'(mem_w), 64'd0);
      repeat (2) begin
         @(negedge clk);
         chk("rst_no_rvalid", 64'(rvalid_v), 64'd0);
      end
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_rvalid", 64'(rvalid_v), 64'd0);
      drive(1'b0, 1'b1, 1'b0, 8'd1, 64'd0);
      drive(1'b1, 1'b1, 1'b0, 8'd200, 64'd0);
      @(negedge clk);
      chk("post_rst_prio", 64'(gnt_v), 64'd1);
      drive(1'b0, 1'b0, 1'b0, 8'd0, 64'd0);
      drive(1'b1, 1'b0, 1'b0, 8'd0, 64'd0);
      repeat (2) @(negedge clk);
      chk("post_rst_rvalid0", 64'(rvalid_v), 64'd1);
      chk("post_rst_rdata", bus.rdata, 64'd555);
      @(negedge clk);

      // Reset in the ISSUE cycle of a write drops mem_w at once
      drive(1'b1, 1'b1, 1'b1, 8'h10, 64'h77);
      @(negedge clk);
      chk("wr_issue_mem_w", 64'(mem_w), 64'd1);
      drive(1'b1, 1'b0, 1'b1, 8'h10, 64'h77);
      rst_n = 1'b0;
      #1;
      chk("rst_async_wr_mem_w", 64'(mem_w), 64'd0);
      @(negedge clk);
      chk("rst_wr_gnt", 64'(gnt_v), 64'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/nv_mem_ctrl.md
# nv_mem_ctrl

Two-port controller that shares the single-port 256 x 64 `nv_memory` between the bitstream decryptor (port 0) and the configuration/debug loader (port 1). Arbitrates round-robin, sequences one memory access at a time and returns read data with a valid pulse. Enforces a sticky key-region lock: after `lock_set`, the key region cannot be written by either port and cannot be read by port 1. Sits directly in front of `nv_memory`, which no other block drives.

## Interface
- `KEY_BASE`, 8'hC0: first address of the protected key region (region = `KEY_BASE`..8'hFF).
- `RD_LAT`, 1: `nv_memory` read latency, in cycles from address presented to `mem_data_out` valid (1..3).
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `p0_req`, `p1_req`  in  1  access request; held until the matching `pX_gnt`.
- `p0_we`, `p1_we`  in  1  1 = write, 0 = read; stable while `req` is high.
- `p0_addr`, `p1_addr`  in  8  word address.
- `p0_wdata`, `p1_wdata`  in  64  write data.
- `p0_gnt`, `p1_gnt`  out  1  one-cycle pulse: request accepted (or rejected, see `err`).
- `p0_err`, `p1_err`  out  1  one-cycle pulse, coincident with `gnt`: access refused by lock.
- `p0_rvalid`, `p1_rvalid`  out  1  one-cycle pulse: `rdata` holds this port's read result.
- `rdata`  out  64  read data; holds until the next read response.
- `lock_set`  in  1  pulse; sets the lock.
- `locked`  out  1  sticky lock status.
- `mem_w`, `mem_addr_in`, `mem_data_in`  out  1/8/64  to `nv_memory`.
- `mem_data_out`  in  64  from `nv_memory`.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any `req`, choose the winner, latch its `we`, `addr` and `wdata`, evaluate the lock using the current `locked`, then go to ISSUE.
- Arbitration is round-robin. After reset port 0 has priority. When both ports request, the port not granted last wins. A lone requester always wins.
- ISSUE, one cycle:
  - `gnt` pulses for the winner.
  - Refused access: `err` pulses, `mem_w` stays 0, next state IDLE.
  - Write: `mem_w` = 1 for this cycle only, next state IDLE.
  - Read: address driven with `mem_w` = 0, next state WAIT.
- WAIT lasts `RD_LAT` cycles. `rdata` is captured from `mem_data_out` on the final WAIT edge, then the FSM goes to RESP.
- RESP, one cycle: `rvalid` pulses for the read's owner, then the FSM returns to IDLE.
- Lock rule, applied only when `locked` = 1:
  - A write to `addr` >= `KEY_BASE` from either port is refused.
  - A port-1 read of `addr` >= `KEY_BASE` is refused. `rdata` is unchanged and no `rvalid` is produced.
  - Port-0 reads of the key region are always allowed.
- `lock_set`: `locked` becomes 1 on the next edge and stays 1 until `rst_n`. A `lock_set` arriving in the arbitration cycle does not affect that access.
- `mem_addr_in` and `mem_data_in` are registered. They are held through WAIT and RESP and keep their last value in IDLE.

## Timing
- Reset values: all `gnt`, `err` and `rvalid` = 0; `rdata` = 0; `locked` = 0; `mem_w` = 0; `mem_addr_in` = 0; `mem_data_in` = 0; state = IDLE; priority = port 0.
- Reset mid-operation: `mem_w` drops immediately (asynchronous). The in-flight access is abandoned and no `gnt` or `rvalid` follows.
- Write: request seen in cycle 0 → `gnt` and `mem_w` in cycle 1 → IDLE in cycle 2. Two cycles per write.
- Read: `gnt` in cycle 1 → `rvalid` in cycle 2+`RD_LAT` (cycle 3 for the default). Then IDLE.
- Refused access: `gnt` and `err` in cycle 1, IDLE in cycle 2.
- A request arriving while the FSM is busy waits. There is no queue depth beyond the held `req`.
- A requester may drop `req` in its `gnt` cycle. It must drop `req` or present a new request by the following cycle.
- Only one access is outstanding at a time. `gnt` is never asserted on both ports in the same cycle.

## Structure
- Package `nv_mem_pkg`: state enum, `ADDR_W` = 8, `DATA_W` = 64, `MEM_DEPTH` = 256, port index constants.
- Sub-module `nv_rr_arb2`: two-requester round-robin arbiter with a last-grant flop and an update-enable input. Everything else lives in `nv_mem_ctrl`.

## Test plan
- Port 1 writes 64'd256 to address 0, then reads address 0 → `mem_w` high exactly 1 cycle; `p1_rvalid` 3 cycles after read arbitration; `rdata` = 256.
- Both ports continuously request reads of addresses 1 and 200 (preloaded 555 and 2560) → grants alternate p0, p1, p0…; each `rvalid` is on the correct port with the correct data.
- `lock_set`, then port 1 writes address 8'hC8 → `p1_err` with `gnt`; `mem_w` stays 0; a port-0 read of 8'hC8 returns the pre-lock value.
- Locked; port 1 reads 8'hC0 → `err`, no `rvalid`, `rdata` unchanged; port 1 reads 8'hBF → normal response.
- `lock_set` in the same cycle that a port-1 write to 8'hD0 is arbitrated → the write succeeds, `locked` = 1 afterwards, and the next write to 8'hD0 is refused.
- `rst_n` asserted during WAIT of a read → `mem_w`=0 and `locked`=0 immediately, no `rvalid`; after release, port 0 wins a simultaneous request.
